// File: rtl/snake_pkg.sv
// snake_pkg: encodings, field bounds and helpers shared by the snake controller.
// Defining SNAKE_CTRL_PAUSE_EN adds the PAUSE state.
package snake_pkg;
  typedef enum logic [2:0] {
    ST_RESTART,
    ST_START,
    ST_PLAY,
    ST_DIE
`ifdef SNAKE_CTRL_PAUSE_EN
    , ST_PAUSE
`endif
  } state_t;
  localparam logic [1:0] GS_RESTART = 2'b00, GS_START = 2'b01, GS_PLAY = 2'b10, GS_DIE = 2'b11;
  localparam logic [5:0] X_MIN = 6'd1, X_MAX = 6'd38, Y_MIN = 6'd1, Y_MAX = 6'd28;
  localparam logic [5:0] FOOD_X0 = 6'd20, FOOD_Y0 = 6'd15;
  localparam logic [1:0] SPD_0 = 2'd3, SPD_1 = 2'd1, SPD_2 = 2'd2, SPD_3 = 2'd0;
  localparam logic [11:0] LFSR_SEED = 12'hACE;
  function automatic logic in_field(input logic [11:0] c);
    return c[5:0] >= X_MIN && c[5:0] <= X_MAX && c[11:6] >= Y_MIN && c[11:6] <= Y_MAX;
  endfunction
  function automatic logic [1:0] auto_speed(input logic [7:0] s);
    return s < 8'd3 ? SPD_0 : s < 8'd6 ? SPD_1 : s < 8'd9 ? SPD_2 : SPD_3;
  endfunction
endpackage

// File: rtl/snake_key_debounce.sv
// snake_key_debounce: synchronises the raw active-low key and emits a one-cycle pulse
// on each debounced falling edge.
module snake_key_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [1:0]    r_sync;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) r_cnt <= '0;
      else if (r_cnt == CW'(CYCLES - 1)) begin
        r_cnt    <= '0;
        r_stable <= r_sync[1];
        r_press  <= r_stable;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_press = r_press;
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer for the snake datapath (status FSM, food LFSR, growth, speed, blink, score).
// Define SNAKE_CTRL_PAUSE_EN to let a press in PLAY pause and resume the game.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESTART_CYCLES  = 4,
  parameter int ADD_HOLD        = 4,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int BLINK_TOGGLES   = 6,
  parameter int MAX_ADDS        = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_start,
  input  logic [2:0] i_sw,
  input  logic [5:0] i_head_x,
  input  logic [5:0] i_head_y,
  input  logic       i_hit_wall,
  input  logic       i_hit_body,
  output logic [1:0] o_game_status,
  output logic       o_add_cube,
  output logic       o_snake_display,
  output logic [1:0] o_fact_status,
  output logic [5:0] o_food_x,
  output logic [5:0] o_food_y,
  output logic [7:0] o_score
);
  localparam int RW = $clog2(RESTART_CYCLES + 1);
  localparam int HW = $clog2(ADD_HOLD + 1);
  localparam int AW = $clog2(MAX_ADDS + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);
  state_t        r_state, w_next;
  logic          w_press, w_hit, w_eat, w_abort;
  logic [RW-1:0] r_rcnt;
  logic [11:0]   r_lfsr;
  logic          r_reroll;
  logic [5:0]    r_food_x, r_food_y;
  logic          r_add;
  logic [HW-1:0] r_hold;
  logic [AW-1:0] r_adds;
  logic [7:0]    r_score;
  logic [1:0]    r_fact;
  logic          r_disp;
  logic [BW-1:0] r_bcnt;
  logic [TW-1:0] r_tog;
  snake_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key_n(i_key_start),
    .o_press(w_press)
  );
  assign w_hit = i_hit_wall | i_hit_body;
  // A hit in the same cycle as reaching the food takes precedence.
  assign w_eat = r_state == ST_PLAY && !w_hit && !r_add && !r_reroll &&
                 i_head_x == r_food_x && i_head_y == r_food_y;
  assign w_abort = r_state == ST_PLAY && w_next == ST_DIE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESTART: w_next = r_rcnt == RW'(RESTART_CYCLES - 1) ? ST_START : ST_RESTART;
      ST_START:   w_next = w_press ? ST_PLAY : ST_START;
`ifdef SNAKE_CTRL_PAUSE_EN
      ST_PLAY:    w_next = w_hit ? ST_DIE : w_press ? ST_PAUSE : ST_PLAY;
      ST_PAUSE:   w_next = w_press ? ST_PLAY : ST_PAUSE;
`else
      ST_PLAY:    w_next = w_hit ? ST_DIE : ST_PLAY;
`endif
      ST_DIE:     w_next = w_press ? ST_RESTART : ST_DIE;
      default:    w_next = ST_RESTART;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESTART;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_rcnt  <= r_state == ST_RESTART ? r_rcnt + 1'b1 : '0;
    end
  end
  // Fibonacci LFSR, taps 12,11,10,4; candidates are tried every cycle until one lands in the field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr   <= LFSR_SEED;
      r_reroll <= 1'b0;
      r_food_x <= FOOD_X0;
      r_food_y <= FOOD_Y0;
    end else begin
      r_lfsr <= {r_lfsr[10:0], r_lfsr[11] ^ r_lfsr[10] ^ r_lfsr[9] ^ r_lfsr[3]};
      if (w_eat) r_reroll <= 1'b1;
      else if (r_reroll && in_field(r_lfsr)) begin
        r_reroll <= 1'b0;
        r_food_x <= r_lfsr[5:0];
        r_food_y <= r_lfsr[11:6];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add   <= 1'b0;
      r_hold  <= '0;
      r_adds  <= '0;
      r_score <= '0;
    end else if (r_state == ST_RESTART) begin
      r_add   <= 1'b0;
      r_hold  <= '0;
      r_adds  <= '0;
      r_score <= '0;
    end else if (w_abort) begin
      r_add  <= 1'b0;
      r_hold <= '0;
    end else if (w_eat) begin
      r_score <= r_score + {7'd0, r_score != 8'hFF};
      if (r_adds < AW'(MAX_ADDS)) begin
        r_add  <= 1'b1;
        r_hold <= HW'(ADD_HOLD - 1);
        r_adds <= r_adds + 1'b1;
      end
    end else if (r_add) begin
      if (r_hold == '0) r_add <= 1'b0;
      else r_hold <= r_hold - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fact <= SPD_0;
    else r_fact <= i_sw[2] ? auto_speed(r_score) : i_sw[1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= 1'b1;
      r_bcnt <= '0;
      r_tog  <= '0;
    end else if (r_state != ST_DIE) begin
      r_disp <= 1'b1;
      r_bcnt <= '0;
      r_tog  <= '0;
    end else if (r_tog != TW'(BLINK_TOGGLES)) begin
      if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
        r_bcnt <= '0;
        r_disp <= ~r_disp;
        r_tog  <= r_tog + 1'b1;
      end else r_bcnt <= r_bcnt + 1'b1;
    end
  end
  assign o_game_status   = r_state == ST_DIE ? GS_DIE : r_state == ST_PLAY ? GS_PLAY :
                           r_state == ST_RESTART ? GS_RESTART : GS_START;
  assign o_add_cube      = r_add;
  assign o_snake_display = r_disp;
  assign o_fact_status   = r_fact;
  assign o_food_x        = r_food_x;
  assign o_food_y        = r_food_y;
  assign o_score         = r_score;
endmodule
